// File: rtl/input_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_window_buffer
// Description : CNN input-activation buffer. Serial beats of up to
//               N_DIM_ARRAY words fill a circular store. A dilated window of
//               N_DIM_ARRAY taps is read from the oldest word, and a
//               stride-sized advance retires words. FC/EWS modes pass
//               parallel_in straight through. A parallel load and a clear
//               are provided for layer start.
// Revision    : 1.0 - initial release
// ============================================================================
module input_window_buffer #(
  parameter int N_DIM_ARRAY = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int DIL_BITS    = 8,
  parameter int PTR_BITS    = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [2:0]                        mode,
  input  logic [DIL_BITS-1:0]               dilation,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [$clog2(N_DIM_ARRAY):0]      in_count,
  input  logic [N_DIM_ARRAY*DATA_WIDTH-1:0] in_data,
  input  logic                              load_parallel,
  input  logic [N_DIM_ARRAY*DATA_WIDTH-1:0] parallel_in,
  output logic                              win_valid,
  input  logic                              win_advance,
  input  logic [PTR_BITS:0]                 advance_amt,
  output logic [N_DIM_ARRAY*DATA_WIDTH-1:0] out_array,
  output logic [PTR_BITS:0]                 occupancy,
  output logic                              cfg_error
);

  // --------------------------------------------------------------------------
  // Derived widths and mode encodings
  // --------------------------------------------------------------------------
  localparam int LANE_W = $clog2(N_DIM_ARRAY);
  localparam int CNT_W  = LANE_W + 1;
  localparam int OCC_W  = PTR_BITS + 1;
  // Tap offset k*d is formed at full width before the modulo-DEPTH wrap.
  localparam int TAP_W  = DIL_BITS + LANE_W;
  localparam int IDX_W  = TAP_W + PTR_BITS;
  // Window span needs room for (N-1)*d+1 and for DEPTH itself.
  localparam int SPAN_W = TAP_W + PTR_BITS + 1;

  localparam logic [2:0] MODE_FC  = 3'd0;
  localparam logic [2:0] MODE_CNN = 3'd1;
  localparam logic [2:0] MODE_EWS = 3'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] store_q [DEPTH];
  logic [DATA_WIDTH-1:0] store_d [DEPTH];
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  load_parallel_q;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                              w_mode_cnn;
  logic                              w_mode_bypass;
  logic [DIL_BITS-1:0]               w_dil_eff;
  logic [SPAN_W-1:0]                 w_span;
  logic [OCC_W-1:0]                  w_free;
  logic [CNT_W-1:0]                  w_cnt_clamped;
  logic                              w_wr_accept;
  logic [OCC_W-1:0]                  w_wr_cnt;
  logic                              w_adv_accept;
  logic [OCC_W-1:0]                  w_adv_cnt;
  logic [N_DIM_ARRAY*DATA_WIDTH-1:0] w_window;

  assign w_mode_cnn    = (mode == MODE_CNN);
  assign w_mode_bypass = (mode == MODE_FC) || (mode == MODE_EWS);

  // A dilation of zero would collapse every tap onto one word; treat it as 1.
  assign w_dil_eff = (dilation == '0) ? DIL_BITS'(1) : dilation;

  assign w_span    = SPAN_W'(N_DIM_ARRAY - 1) * SPAN_W'(w_dil_eff) + SPAN_W'(1);
  assign cfg_error = (w_span > SPAN_W'(DEPTH));

  assign win_valid = w_mode_cnn && !cfg_error && (SPAN_W'(occ_q) >= w_span);

  // Ready only when a full-width beat fits, so a writer never needs to know
  // how many lanes the store could take.
  assign w_free   = OCC_W'(DEPTH) - occ_q;
  assign in_ready = w_mode_cnn && (w_free >= OCC_W'(N_DIM_ARRAY));

  assign w_cnt_clamped = (in_count > CNT_W'(N_DIM_ARRAY)) ? CNT_W'(N_DIM_ARRAY)
                                                           : in_count;
  assign w_wr_accept   = in_valid && in_ready;
  assign w_wr_cnt      = w_wr_accept ? OCC_W'(w_cnt_clamped) : '0;

  // Retiring more words than are held would underflow occupancy.
  assign w_adv_accept = win_advance && win_valid;
  assign w_adv_cnt    = !w_adv_accept          ? '0
                      : (advance_amt > occ_q)  ? occ_q
                      :                          advance_amt;

  assign occupancy = occ_q;

  // --------------------------------------------------------------------------
  // Window taps: lane k reads store[(rd_ptr + k*d) mod DEPTH]
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_DIM_ARRAY; k++) begin : g_tap
    logic [TAP_W-1:0]    w_off;
    logic [PTR_BITS-1:0] w_idx;

    assign w_off = TAP_W'(k) * TAP_W'(w_dil_eff);
    assign w_idx = PTR_BITS'(IDX_W'(rd_ptr_q) + IDX_W'(w_off));
    assign w_window[k*DATA_WIDTH +: DATA_WIDTH] = store_q[w_idx];
  end

  // Output select: window in CNN mode, bypass in FC/EWS, zero otherwise.
  always_comb begin
    out_array = '0;
    if (w_mode_cnn) begin
      if (win_valid) begin
        out_array = w_window;
      end
    end else if (w_mode_bypass) begin
      out_array = parallel_in;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: clear > non-CNN hold > parallel load > write/advance
  // --------------------------------------------------------------------------
  always_comb begin
    store_d  = store_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;

    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_d[i] = '0;
      end
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else if (!w_mode_cnn) begin
      // Store frozen outside CNN mode; the layer's window is kept intact.
      store_d  = store_q;
    end else if (load_parallel_q) begin
      for (int j = 0; j < N_DIM_ARRAY; j++) begin
        store_d[j] = parallel_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
      rd_ptr_d = '0;
      wr_ptr_d = PTR_BITS'(N_DIM_ARRAY);
      occ_d    = OCC_W'(N_DIM_ARRAY);
    end else begin
      // Writes land at wr_ptr, which is never inside the retired region,
      // so a same-cycle advance cannot collide with them.
      if (w_wr_accept) begin
        for (int j = 0; j < N_DIM_ARRAY; j++) begin
          if (CNT_W'(j) < w_cnt_clamped) begin
            store_d[wr_ptr_q + PTR_BITS'(j)] = in_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      wr_ptr_d = wr_ptr_q + PTR_BITS'(w_wr_cnt);
      rd_ptr_d = rd_ptr_q + PTR_BITS'(w_adv_cnt);
      occ_d    = occ_q + w_wr_cnt - w_adv_cnt;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      occ_q           <= '0;
      load_parallel_q <= 1'b0;
    end else begin
      store_q         <= store_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      occ_q           <= occ_d;
      load_parallel_q <= load_parallel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_window_buffer
// Description : Self-checking bench for input_window_buffer (N=4, DW=8,
//               DEPTH=16): directed vector table, random stimulus against a
//               behavioural model, and an asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_window_buffer;

  localparam int N = 4;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [2:0]  mode;
  logic [7:0]  dilation;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_count;
  logic [31:0] in_data;
  logic        load_parallel;
  logic [31:0] parallel_in;
  logic        win_valid;
  logic        win_advance;
  logic [4:0]  advance_amt;
  logic [31:0] out_array;
  logic [4:0]  occupancy;
  logic        cfg_error;

  int n_cmp = 0;
  int n_err = 0;

  input_window_buffer #(
    .N_DIM_ARRAY(4), .DATA_WIDTH(8), .DEPTH(16), .DIL_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .dilation(dilation),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .in_data(in_data), .load_parallel(load_parallel), .parallel_in(parallel_in),
    .win_valid(win_valid), .win_advance(win_advance), .advance_amt(advance_amt),
    .out_array(out_array), .occupancy(occupancy), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Behavioural reference model (words held as a ring with plain modulo math)
  // --------------------------------------------------------------------------
  logic [7:0] m_mem [D];
  int         m_rd, m_wr, m_occ;
  bit         m_lp;

  function automatic int eff_d();
    return (dilation == 8'd0) ? 1 : int'(dilation);
  endfunction

  function automatic int m_span();
    return (N - 1) * eff_d() + 1;
  endfunction

  function automatic bit m_cfg();
    return m_span() > D;
  endfunction

  function automatic bit m_wv();
    return (mode == 3'd1) && !m_cfg() && (m_occ >= m_span());
  endfunction

  function automatic bit m_ir();
    return (mode == 3'd1) && ((D - m_occ) >= N);
  endfunction

  function automatic logic [31:0] m_out();
    logic [31:0] r;
    r = '0;
    if (mode == 3'd1) begin
      if (m_wv())
        for (int k = 0; k < N; k++) r[k*8 +: 8] = m_mem[(m_rd + k * eff_d()) % D];
    end else if (mode == 3'd0 || mode == 3'd3) begin
      r = parallel_in;
    end
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
    m_rd = 0; m_wr = 0; m_occ = 0; m_lp = 1'b0;
  endtask

  // Applies one clock edge's worth of the buffer's rules to the model.
  task automatic m_step();
    bit wv, ir;
    int cnt, amt;
    wv = m_wv();
    ir = m_ir();
    if (clear) begin
      for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
      m_rd = 0; m_wr = 0; m_occ = 0;
    end else if (mode != 3'd1) begin
      // held
    end else if (m_lp) begin
      for (int j = 0; j < N; j++) m_mem[j] = parallel_in[j*8 +: 8];
      m_rd = 0; m_wr = N % D; m_occ = N;
    end else begin
      cnt = 0; amt = 0;
      if (in_valid && ir) begin
        cnt = (int'(in_count) > N) ? N : int'(in_count);
        for (int j = 0; j < cnt; j++) m_mem[(m_wr + j) % D] = in_data[j*8 +: 8];
        m_wr = (m_wr + cnt) % D;
      end
      if (win_advance && wv) begin
        amt = (int'(advance_amt) > m_occ) ? m_occ : int'(advance_amt);
        m_rd = (m_rd + amt) % D;
      end
      m_occ = m_occ + cnt - amt;
    end
    m_lp = load_parallel;
  endtask

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_occ, input logic e_wv,
                         input logic e_ir, input logic e_cfg, input logic [31:0] e_out);
    chk($sformatf("%s.occupancy", tag), 32'(occupancy), 32'(e_occ));
    chk($sformatf("%s.win_valid", tag), 32'(win_valid), 32'(e_wv));
    chk($sformatf("%s.in_ready", tag),  32'(in_ready),  32'(e_ir));
    chk($sformatf("%s.cfg_error", tag), 32'(cfg_error), 32'(e_cfg));
    chk($sformatf("%s.out_array", tag), out_array, e_out);
  endtask

  task automatic idle_inputs();
    clear = 1'b0; in_valid = 1'b0; in_count = 3'd0; in_data = '0;
    load_parallel = 1'b0; parallel_in = '0; win_advance = 1'b0; advance_amt = '0;
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected just
  // before that cycle's clock edge.
  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  dil;
    logic        clr;
    logic        iv;
    logic [2:0]  cnt;
    logic [31:0] din;
    logic        lp;
    logic [31:0] par;
    logic        adv;
    logic [4:0]  amt;
    logic [4:0]  e_occ;
    logic        e_wv;
    logic        e_ir;
    logic        e_cfg;
    logic [31:0] e_out;
  } vec_t;

  vec_t tbl[$];

  initial begin
    idle_inputs();
    mode = 3'd1; dilation = 8'd1;
    reset = 1'b0;
    m_reset();

    // mode  dil  clr iv  cnt  din  lp  par  adv amt | occ wv ir cfg out
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h04030201, 1'b0, 32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h08070605, 1'b0, 32'h0,        1'b0, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 32'h04030201});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd2,  5'd8,  1'b1, 1'b1, 1'b0, 32'h04030201});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd2, 32'h00000A09, 1'b0, 32'h0,        1'b1, 5'd1,  5'd6,  1'b1, 1'b1, 1'b0, 32'h06050403});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd7,  1'b1, 1'b1, 1'b0, 32'h07060504});
    tbl.push_back('{3'd1, 8'd1, 1'b1, 1'b1, 3'd4, 32'h0C0C0C0C, 1'b0, 32'h0,        1'b1, 5'd1,  5'd7,  1'b1, 1'b1, 1'b0, 32'h07060504});
    tbl.push_back('{3'd1, 8'd2, 1'b0, 1'b1, 3'd4, 32'h03020100, 1'b0, 32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd2, 1'b0, 1'b1, 3'd4, 32'h07060504, 1'b0, 32'h0,        1'b0, 5'd0,  5'd4,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd2, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 32'h06040200});
    tbl.push_back('{3'd1, 8'd8, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd8,  1'b0, 1'b1, 1'b1, 32'h0});
    tbl.push_back('{3'd1, 8'd0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 32'h03020100});
    tbl.push_back('{3'd1, 8'd5, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd8,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h0B0A0908, 1'b0, 32'h0,        1'b0, 5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 32'h03020100});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd1, 32'hFFFFFF0C, 1'b0, 32'h0,        1'b0, 5'd0,  5'd12, 1'b1, 1'b1, 1'b0, 32'h03020100});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h63636363, 1'b0, 32'h0,        1'b0, 5'd0,  5'd13, 1'b1, 1'b0, 1'b0, 32'h03020100});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h63636363, 1'b0, 32'h0,        1'b1, 5'd4,  5'd13, 1'b1, 1'b0, 1'b0, 32'h03020100});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h100F0E0D, 1'b0, 32'h0,        1'b0, 5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 32'h07060504});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd9,  5'd13, 1'b1, 1'b0, 1'b0, 32'h07060504});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 32'h100F0E0D});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd31, 5'd4,  1'b1, 1'b1, 1'b0, 32'h100F0E0D});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b1, 32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd4, 32'h01010101, 1'b0, 32'h281E140A, 1'b1, 5'd1,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h11111111, 1'b0, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 32'h281E140A});
    tbl.push_back('{3'd0, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 5'd0,  5'd4,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{3'd3, 8'd1, 1'b0, 1'b1, 3'd4, 32'h0,        1'b0, 32'h12345678, 1'b1, 5'd1,  5'd4,  1'b0, 1'b0, 1'b0, 32'h12345678});
    tbl.push_back('{3'd2, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h55555555, 1'b0, 5'd0,  5'd4,  1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 32'h281E140A});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b1, 3'd7, 32'h44332211, 1'b0, 32'h0,        1'b0, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 32'h281E140A});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 32'h281E140A});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd4,  5'd8,  1'b1, 1'b1, 1'b0, 32'h281E140A});
    tbl.push_back('{3'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 32'h44332211});

    // Reset state while reset is held low.
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", 5'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      mode = tbl[i].mode; dilation = tbl[i].dil; clear = tbl[i].clr;
      in_valid = tbl[i].iv; in_count = tbl[i].cnt; in_data = tbl[i].din;
      load_parallel = tbl[i].lp; parallel_in = tbl[i].par;
      win_advance = tbl[i].adv; advance_amt = tbl[i].amt;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_occ, tbl[i].e_wv, tbl[i].e_ir,
              tbl[i].e_cfg, tbl[i].e_out);
      @(posedge clk);
      m_step();
      @(negedge clk);
    end

    // Randomised stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 19));
      mode = (r < 16) ? 3'd1 : (r == 16) ? 3'd0 : (r == 17) ? 3'd3 : 3'($urandom_range(2, 7));
      dilation = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      clear = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_count = 3'($urandom_range(0, 7));
      in_data = $urandom;
      load_parallel = ($urandom_range(0, 29) == 0);
      parallel_in = $urandom;
      win_advance = ($urandom_range(0, 1) == 1);
      advance_amt = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      #1;
      chk("rnd.occupancy", 32'(occupancy), 32'(m_occ));
      chk("rnd.win_valid", 32'(win_valid), 32'(m_wv()));
      chk("rnd.in_ready",  32'(in_ready),  32'(m_ir()));
      chk("rnd.cfg_error", 32'(cfg_error), 32'(m_cfg()));
      chk("rnd.out_array", out_array, m_out());
      @(posedge clk);
      m_step();
      @(negedge clk);
    end

    // Asynchronous reset mid-stream: outputs return to reset values at once.
    idle_inputs();
    mode = 3'd1; dilation = 8'd1;
    in_valid = 1'b1; in_count = 3'd4; in_data = 32'hA4A3A2A1;
    @(posedge clk);
    m_step();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 5'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    m_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk_all("post_reset", 5'd0, 1'b0, 1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
